// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core-side request/response bundle plus the shared RAM port
// of the two-core memory arbiter.
`default_nettype none

interface mem_arbiter_if #(
   parameter int WORD_W = 32,
   parameter int CPUS   = 2
);
   logic [CPUS-1:0]             iREN;
   logic [CPUS-1:0]             dREN;
   logic [CPUS-1:0]             dWEN;
   logic [CPUS-1:0][WORD_W-1:0] iaddr;
   logic [CPUS-1:0][WORD_W-1:0] daddr;
   logic [CPUS-1:0][WORD_W-1:0] dstore;
   logic [CPUS-1:0]             iwait;
   logic [CPUS-1:0]             dwait;
   logic [CPUS-1:0][WORD_W-1:0] iload;
   logic [CPUS-1:0][WORD_W-1:0] dload;
   logic                        ramREN;
   logic                        ramWEN;
   logic [WORD_W-1:0]           ramaddr;
   logic [WORD_W-1:0]           ramstore;
   logic [WORD_W-1:0]           ramload;
   logic [1:0]                  ramstate;

   // Arbiter side
   modport slave (
      input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   // Cores and RAM side
   modport master (
      output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of the two cores' icache/dcache requests to a single
// RAM port; data beats instruction, round-robin between cores within a class.
`default_nettype none

module mem_arbiter #(
   parameter int WORD_W = 32,
   parameter int CPUS   = 2
) (
   input  wire logic     CLK,
   input  wire logic     RST,
   mem_arbiter_if.slave  bus
);
   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'b10;

   state_t          state, state_nx;
   logic            grant_core, grant_core_nx;
   logic            grant_d, grant_d_nx;
   logic            rr, rr_nx;

   logic [CPUS-1:0] d_req;
   logic [CPUS-1:0] cls_req;
   logic            pick_d;
   logic            pick_core;
   logic            granted_active;
   logic [CPUS-1:0] iwait_c;
   logic [CPUS-1:0] dwait_c;
   logic            ram_ren_c;
   logic            ram_wen_c;

   assign d_req = bus.dREN | bus.dWEN;

   // Winner selection: any data request wins the class, rr breaks core ties.
   always_comb begin
      pick_d    = |d_req;
      cls_req   = pick_d ? d_req : bus.iREN;
      pick_core = (cls_req[0] & cls_req[1]) ? rr : cls_req[1];
   end

   assign granted_active = grant_d ? d_req[grant_core] : bus.iREN[grant_core];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         grant_core <= 1'b0;
         grant_d    <= 1'b0;
         rr         <= 1'b0;
      end else begin
         state      <= state_nx;
         grant_core <= grant_core_nx;
         grant_d    <= grant_d_nx;
         rr         <= rr_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      grant_core_nx = grant_core;
      grant_d_nx    = grant_d;
      rr_nx         = rr;
      ram_ren_c     = 1'b0;
      ram_wen_c     = 1'b0;
      iwait_c       = '1;
      dwait_c       = '1;

      case (state)
         IDLE: begin
            if (|d_req || |bus.iREN) begin
               grant_core_nx = pick_core;
               grant_d_nx    = pick_d;
               state_nx      = SERVE;
            end
         end
         SERVE: begin
            if (grant_d) begin
               ram_wen_c = bus.dWEN[grant_core];
               ram_ren_c = bus.dREN[grant_core] & ~bus.dWEN[grant_core];
            end else begin
               ram_ren_c = bus.iREN[grant_core];
            end

            // A dropped request is abandoned silently; only ACCESS completes.
            if (!granted_active) begin
               state_nx = IDLE;
            end else if (bus.ramstate == RAM_ACCESS) begin
               if (grant_d) dwait_c[grant_core] = 1'b0;
               else         iwait_c[grant_core] = 1'b0;
               rr_nx    = ~grant_core;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (RST) begin
         ram_ren_c = 1'b0;
         ram_wen_c = 1'b0;
         iwait_c   = '1;
         dwait_c   = '1;
      end
   end

   assign bus.ramREN   = ram_ren_c;
   assign bus.ramWEN   = ram_wen_c;
   assign bus.iwait    = iwait_c;
   assign bus.dwait    = dwait_c;
   assign bus.ramaddr  = grant_d ? bus.daddr[grant_core] : bus.iaddr[grant_core];
   assign bus.ramstore = bus.dstore[grant_core];

   generate
      for (genvar c = 0; c < CPUS; c++) begin : g_load
         assign bus.iload[c] = bus.ramload;
         assign bus.dload[c] = bus.ramload;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with hand-computed
// expectations; the bench plays both cores and the RAM.
`default_nettype none

module tb_mem_arbiter;
   localparam int WORD_W = 32;
   localparam int CPUS   = 2;

   localparam logic [1:0] FREE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] ACCESS = 2'b10;
   localparam logic [1:0] ERROR  = 2'b11;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;

   mem_arbiter_if #(.WORD_W(WORD_W), .CPUS(CPUS)) bus ();

   mem_arbiter #(.WORD_W(WORD_W), .CPUS(CPUS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      bus.iREN     = '0;
      bus.dREN     = '0;
      bus.dWEN     = '0;
      bus.iaddr    = '0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.ramload  = '0;
      bus.ramstate = FREE;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.iREN = 2'b11; bus.dREN = 2'b11; bus.dWEN = 2'b11;
      bus.ramstate = ACCESS;
      next_cycle();
      next_cycle();
      sample();
      checks++; if (bus.iwait !== 2'b11) begin errors++; $display("FAIL reset_iwait got %b want 11", bus.iwait); end
      checks++; if (bus.dwait !== 2'b11) begin errors++; $display("FAIL reset_dwait got %b want 11", bus.dwait); end
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_en got %b want 00", {bus.ramREN, bus.ramWEN}); end
      next_cycle();
      clear_inputs();
      RST = 1'b0;
   endtask

   task automatic test_single_iread();
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h40;
      sample();
      checks++; if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL iread_c1 got iwait=%b ren=%b want 11 0", bus.iwait, bus.ramREN); end
      next_cycle();
      bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
      sample();
      checks++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL iread_en got %b%b want 10", bus.ramREN, bus.ramWEN); end
      checks++; if (bus.ramaddr !== 32'h40) begin errors++; $display("FAIL iread_addr got %h want 00000040", bus.ramaddr); end
      checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL iread_iwait got %b want 10", bus.iwait); end
      checks++; if (bus.iload[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL iread_iload got %h want deadbeef", bus.iload[0]); end
      checks++; if (bus.dload[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL iread_dload1 got %h want deadbeef", bus.dload[1]); end
      next_cycle();
      bus.iREN = '0; bus.ramstate = FREE;
      sample();
      checks++; if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL iread_c3 got iwait=%b ren=%b want 11 0", bus.iwait, bus.ramREN); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_d_beats_i();
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h80;
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h200;
      sample();
      checks++; if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) begin errors++; $display("FAIL dbi_idle got ren=%b dwait=%b want 0 11", bus.ramREN, bus.dwait); end
      next_cycle();
      bus.ramstate = ACCESS; bus.ramload = 32'h1234;
      sample();
      checks++; if (bus.ramaddr !== 32'h200 || bus.ramREN !== 1'b1) begin errors++; $display("FAIL dbi_data got addr=%h ren=%b want 200 1", bus.ramaddr, bus.ramREN); end
      checks++; if (bus.dwait !== 2'b10 || bus.iwait !== 2'b11) begin errors++; $display("FAIL dbi_dwait got d=%b i=%b want 10 11", bus.dwait, bus.iwait); end
      checks++; if (bus.dload[0] !== 32'h1234) begin errors++; $display("FAIL dbi_dload got %h want 1234", bus.dload[0]); end
      next_cycle();
      bus.dREN = '0; bus.ramstate = FREE;
      sample();
      checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11) begin errors++; $display("FAIL dbi_gap got ren=%b iwait=%b want 0 11", bus.ramREN, bus.iwait); end
      next_cycle();
      bus.ramstate = ACCESS;
      sample();
      checks++; if (bus.ramaddr !== 32'h80 || bus.ramREN !== 1'b1) begin errors++; $display("FAIL dbi_instr got addr=%h ren=%b want 80 1", bus.ramaddr, bus.ramREN); end
      checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL dbi_iwait got %b want 10", bus.iwait); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic [WORD_W-1:0] exp_addr;
      logic [WORD_W-1:0] exp_store;
      logic [1:0]        exp_dwait;
      RST = 1'b1;
      next_cycle();
      RST = 1'b0;
      bus.dWEN = 2'b11;
      bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h20;
      bus.dstore[0] = 32'hA0; bus.dstore[1] = 32'hB0;
      for (int g = 0; g < 3; g++) begin
         exp_addr  = (g == 1) ? 32'h20 : 32'h10;
         exp_store = (g == 1) ? 32'hB0 : 32'hA0;
         exp_dwait = (g == 1) ? 2'b01 : 2'b10;
         bus.ramstate = FREE;
         sample();
         checks++; if (bus.ramWEN !== 1'b0 || bus.dwait !== 2'b11) begin errors++; $display("FAIL rr_idle%0d got wen=%b dwait=%b want 0 11", g, bus.ramWEN, bus.dwait); end
         next_cycle();
         bus.ramstate = ACCESS;
         sample();
         checks++; if (bus.ramaddr !== exp_addr || bus.ramstore !== exp_store) begin errors++; $display("FAIL rr_grant%0d got addr=%h store=%h want %h %h", g, bus.ramaddr, bus.ramstore, exp_addr, exp_store); end
         checks++; if (bus.ramWEN !== 1'b1 || bus.dwait !== exp_dwait) begin errors++; $display("FAIL rr_dwait%0d got wen=%b dwait=%b want 1 %b", g, bus.ramWEN, bus.dwait, exp_dwait); end
         next_cycle();
      end
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_write_priority();
      bus.dREN[1] = 1'b1; bus.dWEN[1] = 1'b1;
      bus.daddr[1] = 32'h100; bus.dstore[1] = 32'h55;
      sample();
      next_cycle();
      bus.ramstate = BUSY;
      sample();
      checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL wr_en got wen=%b ren=%b want 1 0", bus.ramWEN, bus.ramREN); end
      checks++; if (bus.ramaddr !== 32'h100 || bus.ramstore !== 32'h55) begin errors++; $display("FAIL wr_bus got addr=%h store=%h want 100 55", bus.ramaddr, bus.ramstore); end
      checks++; if (bus.dwait !== 2'b11) begin errors++; $display("FAIL wr_busy got %b want 11", bus.dwait); end
      next_cycle();
      bus.ramstate = ACCESS;
      sample();
      checks++; if (bus.dwait !== 2'b01) begin errors++; $display("FAIL wr_done got %b want 01", bus.dwait); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_error_retry();
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h300;
      sample();
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         bus.ramstate = ERROR;
         sample();
         checks++; if (bus.dwait !== 2'b11 || bus.ramREN !== 1'b1) begin errors++; $display("FAIL err_hold%0d got dwait=%b ren=%b want 11 1", k, bus.dwait, bus.ramREN); end
      end
      next_cycle();
      bus.ramstate = ACCESS;
      sample();
      checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL err_done got %b want 10", bus.dwait); end
      next_cycle();
      clear_inputs();
      sample();
      checks++; if (bus.dwait !== 2'b11) begin errors++; $display("FAIL err_after got %b want 11", bus.dwait); end
      next_cycle();
   endtask

   task automatic test_drop();
      bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h500; bus.iaddr[0] = 32'h600;
      sample();
      next_cycle();
      sample();
      checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h500) begin errors++; $display("FAIL drop_serve got ren=%b addr=%h want 1 500", bus.ramREN, bus.ramaddr); end
      next_cycle();
      bus.iREN = '0; bus.ramstate = ACCESS;
      sample();
      checks++; if (bus.iwait !== 2'b11 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL drop_wait got iwait=%b ren=%b want 11 0", bus.iwait, bus.ramREN); end
      next_cycle();
      bus.iREN = 2'b11; bus.ramstate = FREE;
      sample();
      checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL drop_idle got ren=%b want 0", bus.ramREN); end
      next_cycle();
      bus.ramstate = ACCESS;
      sample();
      checks++; if (bus.ramaddr !== 32'h500 || bus.iwait !== 2'b01) begin errors++; $display("FAIL drop_rr got addr=%h iwait=%b want 500 01", bus.ramaddr, bus.iwait); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_reset_mid_serve();
      bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h700;
      next_cycle();
      bus.ramstate = ACCESS;
      sample();
      checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL rst_pre got %b want 10", bus.dwait); end
      next_cycle();
      clear_inputs();
      bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h700;
      next_cycle();
      sample();
      checks++; if (bus.ramWEN !== 1'b1) begin errors++; $display("FAIL rst_serve got wen=%b want 1", bus.ramWEN); end
      RST = 1'b1;
      #1;
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00 || bus.dwait !== 2'b11 || bus.iwait !== 2'b11) begin errors++; $display("FAIL rst_hold got en=%b%b d=%b i=%b want 00 11 11", bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait); end
      next_cycle();
      RST = 1'b0;
      bus.dWEN = 2'b11; bus.daddr[1] = 32'h800;
      sample();
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00 || bus.dwait !== 2'b11 || bus.iwait !== 2'b11) begin errors++; $display("FAIL rst_idle got en=%b%b d=%b i=%b want 00 11 11", bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait); end
      next_cycle();
      bus.ramstate = ACCESS;
      sample();
      checks++; if (bus.ramaddr !== 32'h700 || bus.dwait !== 2'b10) begin errors++; $display("FAIL rst_rr got addr=%h dwait=%b want 700 10", bus.ramaddr, bus.dwait); end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST    = 1'b1;
      clear_inputs();
      test_reset();
      test_single_iread();
      test_d_beats_i();
      test_round_robin();
      test_write_priority();
      test_error_retry();
      test_drop();
      test_reset_mid_serve();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
